demux_1to2_8bits_stream: RTL and testbench

//  Registered 1-to-2 demultiplexer: inverse of the 2:1 8-bit mux. Routes one input byte stream
//  to OUT1 or OUT2, chosen per beat by SEL, with per-output FIFO buffering and valid/ready

---
 rtl/demux_1to2_8bits_stream.sv | 101 ++++++++++
 tb/tb_demux_1to2_8bits_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_8bits_stream.sv
// Registered 1-to-2 byte-stream demultiplexer: each input beat is steered by sel into one of two
// small FIFOs, each drained independently by its own consumer, with per-output beat counters.
module demux_1to2_8bits_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    // Handshake: a beat moves on a rising edge only when valid and ready are both high;
    // ready never depends on valid, and a stalled producer holds in/sel stable.

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    logic [PW-1:0]    wr1, rd1, wr2, rd2;
    logic [OW-1:0]    occ1, occ2;
    logic             full1, full2, empty1, empty2;
    logic             push1, push2, pop1, pop2;

    assign full1  = (occ1 == OW'(DEPTH));
    assign full2  = (occ2 == OW'(DEPTH));
    assign empty1 = (occ1 == '0);
    assign empty2 = (occ2 == '0);

    // Fullness is judged on current occupancy only, so a same-cycle pop never frees a slot.
    assign in_ready = !rst && (sel ? !full2 : !full1);

    assign push1 = in_valid && in_ready && !sel;
    assign push2 = in_valid && in_ready &&  sel;
    assign pop1  = !empty1 && out1_ready;
    assign pop2  = !empty2 && out2_ready;

    assign out1_valid = !empty1;
    assign out2_valid = !empty2;
    assign out1       = empty1 ? '0 : mem1[rd1];
    assign out2       = empty2 ? '0 : mem2[rd2];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr1  <= '0;
            rd1  <= '0;
            occ1 <= '0;
            cnt1 <= '0;
        end else begin
            if (push1) begin
                mem1[wr1] <= in;
                wr1       <= wr1 + 1'b1;
                cnt1      <= cnt1 + 1'b1;
            end
            if (pop1) begin
                rd1 <= rd1 + 1'b1;
            end
            if (push1 && !pop1) begin
                occ1 <= occ1 + 1'b1;
            end else if (pop1 && !push1) begin
                occ1 <= occ1 - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr2  <= '0;
            rd2  <= '0;
            occ2 <= '0;
            cnt2 <= '0;
        end else begin
            if (push2) begin
                mem2[wr2] <= in;
                wr2       <= wr2 + 1'b1;
                cnt2      <= cnt2 + 1'b1;
            end
            if (pop2) begin
                rd2 <= rd2 + 1'b1;
            end
            if (push2 && !pop2) begin
                occ2 <= occ2 + 1'b1;
            end else if (pop2 && !push2) begin
                occ2 <= occ2 - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1to2_8bits_stream.sv
// Directed bench for demux_1to2_8bits_stream (DEPTH=2, CNT_W=4 so counter wrap is reachable).
module tb_demux_1to2_8bits_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2;
    logic             out2_valid;
    logic             out2_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    int compared;
    int mismatched;

    demux_1to2_8bits_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2       (out2),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge; one call = one rising edge.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
        in_valid = v;
        sel      = s;
        in       = d;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in         = '0;
        in_valid   = 1'b0;
        sel        = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // T1: load one beat per FIFO, then hold reset for two cycles
        drive(1'b1, 1'b0, 8'h77);
        cycle();
        drive(1'b1, 1'b1, 8'h88);
        cycle();
        drive(1'b0, 1'b0, 8'h00);
        check("t1_pre_out1", {8'h0, out1}, 16'h77);
        check("t1_pre_out2", {8'h0, out2}, 16'h88);
        rst = 1'b1;
        #1;
        check("t1_ready_in_rst", {15'h0, in_ready}, 16'h0);
        cycle();
        check("t1_v1", {15'h0, out1_valid}, 16'h0);
        check("t1_v2", {15'h0, out2_valid}, 16'h0);
        check("t1_o1", {8'h0, out1}, 16'h0);
        check("t1_o2", {8'h0, out2}, 16'h0);
        check("t1_c1", {12'h0, cnt1}, 16'h0);
        check("t1_c2", {12'h0, cnt2}, 16'h0);
        cycle();
        rst = 1'b0;

        // T2: routing with both consumers ready
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h11);
        check("t2_ready", {15'h0, in_ready}, 16'h1);
        cycle();
        check("t2_o1_a", {8'h0, out1}, 16'h11);
        check("t2_v1_a", {15'h0, out1_valid}, 16'h1);
        drive(1'b1, 1'b1, 8'h22);
        cycle();
        check("t2_v1_b", {15'h0, out1_valid}, 16'h0);
        check("t2_o2", {8'h0, out2}, 16'h22);
        drive(1'b1, 1'b0, 8'h33);
        cycle();
        check("t2_o1_b", {8'h0, out1}, 16'h33);
        check("t2_v2_done", {15'h0, out2_valid}, 16'h0);
        drive(1'b0, 1'b0, 8'h00);
        check("t2_c1", {12'h0, cnt1}, 16'h2);
        check("t2_c2", {12'h0, cnt2}, 16'h1);
        cycle();
        check("t2_v1_c", {15'h0, out1_valid}, 16'h0);

        // T3: fill FIFO1, other output keeps flowing
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hA0);
        cycle();
        drive(1'b1, 1'b0, 8'hA1);
        cycle();
        drive(1'b1, 1'b0, 8'hA2);
        check("t3_blocked", {15'h0, in_ready}, 16'h0);
        drive(1'b1, 1'b1, 8'hB0);
        check("t3_ready_sel1", {15'h0, in_ready}, 16'h1);
        cycle();
        drive(1'b0, 1'b0, 8'h00);
        check("t3_o2", {8'h0, out2}, 16'hB0);
        check("t3_o1_head", {8'h0, out1}, 16'hA0);
        check("t3_c1", {12'h0, cnt1}, 16'h4);
        check("t3_c2", {12'h0, cnt2}, 16'h2);
        out1_ready = 1'b1;
        cycle();
        check("t3_o1_next", {8'h0, out1}, 16'hA1);
        cycle();
        check("t3_v1_drained", {15'h0, out1_valid}, 16'h0);

        // T4: push refused into a full FIFO even with a same-cycle pop
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hC0);
        cycle();
        drive(1'b1, 1'b0, 8'hC1);
        cycle();
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hC2);
        check("t4_full_blocked", {15'h0, in_ready}, 16'h0);
        cycle();
        check("t4_o1_c1", {8'h0, out1}, 16'hC1);
        check("t4_ready_again", {15'h0, in_ready}, 16'h1);
        cycle();
        drive(1'b0, 1'b0, 8'h00);
        check("t4_o1_c2", {8'h0, out1}, 16'hC2);
        check("t4_c1", {12'h0, cnt1}, 16'h7);
        cycle();
        check("t4_v1_drained", {15'h0, out1_valid}, 16'h0);

        // T5: counter wrap, 17 beats to OUT2 from a cleared state
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out2_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            cycle();
        end
        drive(1'b0, 1'b0, 8'h00);
        check("t5_c2_wrap", {12'h0, cnt2}, 16'h1);
        check("t5_c1", {12'h0, cnt1}, 16'h0);
        check("t5_o2_last", {8'h0, out2}, 16'h10);
        cycle();
        check("t5_v2_drained", {15'h0, out2_valid}, 16'h0);

        // T6: reset mid-operation discards buffered beats
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h61);
        cycle();
        drive(1'b1, 1'b1, 8'h62);
        cycle();
        drive(1'b0, 1'b0, 8'h00);
        check("t6_pre_c2", {12'h0, cnt2}, 16'h2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_v1_lost", {15'h0, out1_valid}, 16'h0);
        check("t6_v2_lost", {15'h0, out2_valid}, 16'h0);
        drive(1'b1, 1'b1, 8'h5C);
        cycle();
        drive(1'b0, 1'b0, 8'h00);
        check("t6_o2", {8'h0, out2}, 16'h5C);
        check("t6_c2", {12'h0, cnt2}, 16'h1);
        check("t6_c1", {12'h0, cnt1}, 16'h0);
        check("t6_v1", {15'h0, out1_valid}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
